// File: rtl/speed_uart_formatter.sv
// speed_uart_formatter: binary speed to "SPD=dddd\r\n" byte stream.
// Shift-add-3 conversion, one input bit per clock.
module speed_uart_formatter #(
    parameter int SPEED_WIDTH = 10,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic [SPEED_WIDTH-1:0] i_speed,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic                   o_tx_start,
    output logic [7:0]             o_tx_data,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_msg_done
);
    // one spare BCD digit above NUM_DIGITS flags saturation
    localparam int BCD_N   = (NUM_DIGITS >= 5) ? NUM_DIGITS + 1 : 5;
    localparam int BCD_W   = 4 * BCD_N;
    localparam int MSG_LEN = NUM_DIGITS + 6;
    localparam int IDX_W   = $clog2(MSG_LEN);
    localparam int CNT_W   = $clog2(SPEED_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(MSG_LEN - 1);
    localparam logic [IDX_W-1:0] CR_IDX = IDX_W'(MSG_LEN - 2);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SPEED_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, CONVERT, LOAD, WAIT_DONE, FINISH
    } state_t;

    state_t                 r_state, w_next;
    logic [SPEED_WIDTH-1:0] r_shift;
    logic [BCD_W-1:0]       r_bcd, w_adj;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_tx_start, r_msg_done;
    logic [7:0]             r_tx_data, w_byte;
    logic [3:0]             w_nib;
    logic                   w_sat, w_done_ok;

    assign w_sat     = |r_bcd[BCD_W-1:4*NUM_DIGITS];
    // a done arriving with our own start pulse belongs to no byte of ours
    assign w_done_ok = i_tx_done && !r_tx_start;

    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < BCD_N; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_nib = 4'd9;
        if (!w_sat) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (r_idx == IDX_W'(4 + k)) begin
                    w_nib = r_bcd[4*(NUM_DIGITS-1-k) +: 4];
                end
            end
        end
        w_byte = {4'h3, w_nib};
        unique case (1'b1)
            r_idx == IDX_W'(0): w_byte = 8'h53;
            r_idx == IDX_W'(1): w_byte = 8'h50;
            r_idx == IDX_W'(2): w_byte = 8'h44;
            r_idx == IDX_W'(3): w_byte = 8'h3D;
            r_idx == CR_IDX:    w_byte = 8'h0D;
            r_idx == LAST:      w_byte = 8'h0A;
            default:            w_byte = {4'h3, w_nib};
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:      if (i_valid) w_next = CONVERT;
            CONVERT:   if (r_cnt == CNT_END) w_next = LOAD;
            LOAD:      w_next = WAIT_DONE;
            WAIT_DONE: begin
                if (w_done_ok) begin
                    w_next = (r_idx == LAST) ? FINISH : LOAD;
                end
            end
            FINISH:    w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_msg_done <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_tx_start <= 1'b0;
            r_msg_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_shift <= i_speed;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                    end
                end
                CONVERT: begin
                    r_bcd   <= (w_adj << 1) | BCD_W'(r_shift[SPEED_WIDTH-1]);
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + 1'b1;
                end
                LOAD: begin
                    r_tx_data  <= w_byte;
                    r_tx_start <= 1'b1;
                end
                WAIT_DONE: begin
                    if (w_done_ok && r_idx != LAST) r_idx <= r_idx + 1'b1;
                end
                FINISH: begin
                    r_msg_done <= 1'b1;
                    r_idx      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_ready    = (r_state == IDLE);
    assign o_busy     = (r_state != IDLE);
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_msg_done = r_msg_done;
endmodule

// File: tb/tb_speed_uart_formatter.sv
// tb_speed_uart_formatter: table vectors, random messages, reset corner.
// Two instances (widths 10 and 14) share stimulus through a selector.
module tb_speed_uart_formatter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, valid, tx_done, sel;
    logic [15:0] speed;
    logic        a_rdy, a_st, a_busy, a_md;
    logic [7:0]  a_dat;
    logic        b_rdy, b_st, b_busy, b_md;
    logic [7:0]  b_dat;
    logic        rdy, st, busy, md;
    logic [7:0]  dat;

    speed_uart_formatter #(.SPEED_WIDTH(10), .NUM_DIGITS(4)) u_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_speed(speed[9:0]),
        .i_valid(valid & ~sel), .o_ready(a_rdy), .o_tx_start(a_st),
        .o_tx_data(a_dat), .i_tx_done(tx_done & ~sel),
        .o_busy(a_busy), .o_msg_done(a_md));

    speed_uart_formatter #(.SPEED_WIDTH(14), .NUM_DIGITS(4)) u_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_speed(speed[13:0]),
        .i_valid(valid & sel), .o_ready(b_rdy), .o_tx_start(b_st),
        .o_tx_data(b_dat), .i_tx_done(tx_done & sel),
        .o_busy(b_busy), .o_msg_done(b_md));

    assign rdy  = sel ? b_rdy  : a_rdy;
    assign st   = sel ? b_st   : a_st;
    assign busy = sel ? b_busy : a_busy;
    assign md   = sel ? b_md   : a_md;
    assign dat  = sel ? b_dat  : a_dat;

    int total = 0;
    int bad = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [15:0] spd;
        bit          sl;
        int          dly;
        int          spur;
        string       dig;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic exp_hdr();
        exp_q.delete();
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h3D);
    endtask

    task automatic exp_from_str(input string dig);
        exp_hdr();
        for (int i = 0; i < 4; i++) exp_q.push_back(dig[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic exp_model(input int v);
        int d;
        exp_hdr();
        for (int k = 3; k >= 0; k--) begin
            d = (v > 9999) ? 9 : (v / (10 ** k)) % 10;
            exp_q.push_back(8'(8'h30 + d));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // spur: 1=done during convert, 2=done with each start, 4=valid mid-message
    task automatic run_msg(input logic [15:0] v, input int dly,
                           input int spur, input string nm);
        int lat, n_md, rdy_bad, stab_bad, pend, tail;
        logic [7:0] held;
        bit fin;
        got_q.delete();
        lat = -1; n_md = 0; rdy_bad = 0; stab_bad = 0;
        pend = 0; tail = 0; fin = 0; held = 8'h00;
        @(negedge clk);
        for (int i = 0; i < 50 && !rdy; i++) @(negedge clk);
        chk({nm, " ready_before"}, rdy, 1);
        speed = v;
        valid = 1'b1;
        for (int cyc = 0; cyc < 1000 && tail < 15; cyc++) begin
            @(negedge clk);
            valid = 1'b0;
            tx_done = 1'b0;
            if (cyc == 0) speed = 16'($urandom);
            if ((spur & 1) != 0 && cyc == 4) tx_done = 1'b1;
            if ((spur & 4) != 0 && cyc == 30 && !fin) begin
                speed = 16'd500;
                valid = 1'b1;
            end
            if (fin) tail++;
            else if (rdy && !md) rdy_bad++;
            if (md) begin
                n_md++;
                fin = 1'b1;
            end
            if (st) begin
                got_q.push_back(dat);
                held = dat;
                pend = dly;
                if (lat < 0) lat = cyc;
                if ((spur & 2) != 0) tx_done = 1'b1;
            end else if (pend > 0) begin
                if (dat !== held) stab_bad++;
                pend--;
                if (pend == 0) tx_done = 1'b1;
            end
        end
        valid = 1'b0;
        tx_done = 1'b0;
        chk({nm, " msg_finished"}, fin, 1);
        chk({nm, " first_start_lat"}, lat, sel ? 15 : 11);
        chk({nm, " msg_done_count"}, n_md, 1);
        chk({nm, " ready_low_while_busy"}, rdy_bad, 0);
        chk({nm, " data_stable"}, stab_bad, 0);
        chk({nm, " idle_after"}, rdy, 1);
        chk({nm, " byte_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s byte%0d", nm, i),
                (i < got_q.size()) ? got_q[i] : 8'hFF, exp_q[i]);
        end
    endtask

    initial begin
        int n, pend, extra;
        tbl[0] = '{16'd57,    1'b0, 20, 0, "0057"};
        tbl[1] = '{16'd0,     1'b0, 3,  0, "0000"};
        tbl[2] = '{16'd1023,  1'b0, 3,  0, "1023"};
        tbl[3] = '{16'd12000, 1'b1, 2,  0, "9999"};
        tbl[4] = '{16'd9999,  1'b1, 2,  0, "9999"};
        tbl[5] = '{16'd16383, 1'b1, 2,  0, "9999"};
        tbl[6] = '{16'd123,   1'b0, 4,  4, "0123"};
        tbl[7] = '{16'd321,   1'b0, 2,  3, "0321"};
        tbl[8] = '{16'd10000, 1'b1, 1,  0, "9999"};
        tbl[9] = '{16'd1000,  1'b1, 1,  3, "1000"};

        rst_n = 1'b0; valid = 1'b0; tx_done = 1'b0;
        sel = 1'b0; speed = 16'd0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk($sformatf("reset%0d ready", s), rdy, 1);
            chk($sformatf("reset%0d busy", s), busy, 0);
            chk($sformatf("reset%0d start", s), st, 0);
            chk($sformatf("reset%0d data", s), dat, 0);
            chk($sformatf("reset%0d msg_done", s), md, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 10; t++) begin
            sel = tbl[t].sl;
            exp_from_str(tbl[t].dig);
            run_msg(tbl[t].spd, tbl[t].dly, tbl[t].spur,
                    $sformatf("vec%0d", t));
        end

        for (int r = 0; r < 16; r++) begin
            logic [15:0] v;
            sel = 1'($urandom);
            v = sel ? 16'($urandom_range(0, 16383))
                    : 16'($urandom_range(0, 1023));
            exp_model(int'(v));
            run_msg(v, $urandom_range(1, 6), $urandom_range(0, 7),
                    $sformatf("rnd%0d v=%0d", r, v));
        end

        // reset dropped in the middle of a message
        sel = 1'b0;
        @(negedge clk);
        speed = 16'd200;
        valid = 1'b1;
        n = 0; pend = 0;
        for (int cyc = 0; cyc < 500 && n < 5; cyc++) begin
            @(negedge clk);
            valid = 1'b0;
            tx_done = 1'b0;
            if (st) begin
                n++;
                pend = 4;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) tx_done = 1'b1;
            end
        end
        chk("midrst starts_before", n, 5);
        rst_n = 1'b0;
        #1;
        chk("midrst ready", rdy, 1);
        chk("midrst busy", busy, 0);
        chk("midrst start", st, 0);
        chk("midrst data", dat, 0);
        chk("midrst msg_done", md, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (st || md) extra++;
        end
        chk("midrst no_activity", extra, 0);
        chk("midrst idle", rdy, 1);
        exp_model(42);
        run_msg(16'd42, 3, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/speed_uart_formatter.md
Name: speed_uart_formatter

Overview:
Converts a binary speed measurement into a fixed-length ASCII message, "SPD=dddd" followed by CR LF, and streams it byte by byte into the UART transmitter.
It sits directly upstream of the UART transmit path: it drives that path's tx start/data inputs and consumes its tx done pulse.
Binary-to-decimal conversion is sequential (shift-add-3), one bit per clock.

Parameters:
SPEED_WIDTH, 10, width of the input speed value; legal range 4..16.
NUM_DIGITS, 4, fixed number of decimal digits emitted; zero-padded on the left.

Ports:
i_clock  input  1  system clock; all logic is on the rising edge.
i_reset_n  input  1  asynchronous active-low reset.
i_speed  input  SPEED_WIDTH  unsigned speed value to send.
i_valid  input  1  request to send i_speed; captured only when o_ready=1.
o_ready  output  1  high when idle and able to accept a new value.
o_tx_start  output  1  one-cycle pulse; starts transmission of o_tx_data.
o_tx_data  output  8  byte to transmit; stable from the o_tx_start cycle until i_tx_done.
i_tx_done  input  1  one-cycle pulse from the transmitter when a byte is finished.
o_busy  output  1  high from capture until the message completes.
o_msg_done  output  1  one-cycle pulse after the last byte (LF) completes.

Behaviour:
- Reset values (asynchronous assert, synchronous release):
  - o_ready=1, o_busy=0, o_tx_start=0, o_tx_data=8'h00, o_msg_done=0.
  - State=IDLE; byte index=0; BCD register=0.
- Message is exactly 8+NUM_DIGITS-4+2 bytes (10 with defaults), in this order:
  - 0x53 'S', 0x50 'P', 0x44 'D', 0x3D '='.
  - NUM_DIGITS ASCII digits, most significant first, each 0x30+digit.
  - 0x0D, 0x0A.
- Saturation: if i_speed exceeds 10^NUM_DIGITS-1, every digit is sent as '9'.
- States:
  - IDLE: o_ready=1. On i_valid=1, latch i_speed, clear the BCD register, go to CONVERT. o_ready and o_busy change on that same edge.
  - CONVERT: runs SPEED_WIDTH cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left, bringing in the next input bit MSB-first. Then check saturation and go to LOAD.
  - LOAD: drive o_tx_data with the byte at the current index and pulse o_tx_start for one cycle. Go to WAIT_DONE.
  - WAIT_DONE: hold o_tx_data. On i_tx_done:
    - If the index is not the last, increment it and go to LOAD.
    - If it is the last, go to FINISH.
  - FINISH: pulse o_msg_done for one cycle, clear the index, go to IDLE. o_ready=1 from the next cycle.
- Latency:
  - The first o_tx_start is asserted SPEED_WIDTH+1 cycles after the capture edge (11 with defaults).
  - Each subsequent o_tx_start comes 1 cycle after the i_tx_done that finished the previous byte.
  - o_msg_done comes 1 cycle after the final i_tx_done.
- Boundary conditions:
  - i_valid while o_ready=0 is ignored; it is neither queued nor allowed to corrupt the latched value.
  - i_tx_done in IDLE, CONVERT, LOAD or FINISH is ignored. A done coincident with o_tx_start does not advance the index.
  - Changes to i_speed after capture have no effect on the message in flight.
  - Reset mid-message drops the message immediately and issues no further starts. A late i_tx_done after reset release is ignored because the block is in IDLE.
  - i_valid held high continuously produces back-to-back messages. A new capture occurs on the first cycle o_ready=1 after FINISH.

Test Plan:
- i_speed=57, i_valid pulse, transmitter model returning i_tx_done 20 cycles after each start -> bytes 53 50 44 3D 30 30 35 37 0D 0A. First start 11 cycles after capture. o_msg_done pulses exactly once.
- i_speed=0, then i_speed=1023 -> "SPD=0000\r\n", then "SPD=1023\r\n". Check o_tx_data is stable throughout every WAIT_DONE.
- SPEED_WIDTH=14, i_speed=12000 -> digits 39 39 39 39 (saturated). i_speed=9999 -> the same bytes without saturation. Check 16383 also saturates.
- i_valid pulsed with i_speed=500 while busy sending 123 -> only "SPD=0123\r\n" is sent. o_ready stays 0 for the whole message.
- Spurious i_tx_done injected during CONVERT and on the same cycle as o_tx_start -> byte sequence is unchanged and no byte is skipped.
- i_reset_n asserted after the 5th byte's start -> all outputs go to reset values within the same cycle. After release, one i_tx_done is ignored. A new request for 42 yields a full, correct message.
